// File: rtl/rs_encode_stream_out_sched.sv
// Output-side scheduler for the striped RS encode stream: drains encoded data lines
// from the RS units in round-robin block order, banks parity, then replays it per block.
module rs_encode_stream_out_sched #(
   parameter int NUM_REQ_BLOCKS   = 16,
   parameter int NUM_REQ_BLOCKS_W = $clog2(NUM_REQ_BLOCKS),
   parameter int DATA_W           = 256,
   parameter int NUM_LINES        = 8,
   parameter int NUM_RS_UNITS     = 4,
   parameter int NUM_RS_UNITS_W   = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
   parameter int PARITY_W         = 256
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_val,
   input  logic [NUM_REQ_BLOCKS_W:0]        req_num_blocks,
   output logic                             req_rdy,
   input  logic [NUM_RS_UNITS-1:0]          unit_line_vals,
   input  logic [NUM_RS_UNITS*DATA_W-1:0]   unit_lines,
   input  logic [NUM_RS_UNITS*PARITY_W-1:0] unit_paritys,
   output logic [NUM_RS_UNITS-1:0]          unit_line_rdys,
   output logic                             dst_val,
   output logic [DATA_W-1:0]                dst_data,
   output logic                             dst_last,
   input  logic                             dst_rdy,
   output logic                             parity_mem_wr_val,
   output logic [NUM_REQ_BLOCKS_W-1:0]      parity_mem_wr_addr,
   output logic [PARITY_W-1:0]              parity_mem_wr_data,
   output logic                             parity_mem_rd_req_val,
   output logic [NUM_REQ_BLOCKS_W-1:0]      parity_mem_rd_req_addr,
   input  logic                             parity_mem_rd_req_rdy,
   input  logic                             parity_mem_rd_resp_val,
   input  logic [PARITY_W-1:0]              parity_mem_rd_resp_data,
   output logic                             parity_mem_rd_resp_rdy
);

   localparam int LINE_W = $clog2(NUM_LINES);
   localparam int CNT_W  = NUM_REQ_BLOCKS_W + 1;

   typedef enum logic [1:0] {IDLE, DATA, PAR_REQ, PAR_RESP} state_t;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          num_blocks_reg, num_blocks_next;
   logic [CNT_W-1:0]          block_cnt_reg, block_cnt_next;
   logic [CNT_W-1:0]          rd_cnt_reg, rd_cnt_next;
   logic [LINE_W-1:0]         line_cnt_reg, line_cnt_next;
   logic [NUM_RS_UNITS_W-1:0] unit_sel_reg, unit_sel_next;

   logic [DATA_W-1:0]   line_arr   [NUM_RS_UNITS];
   logic [PARITY_W-1:0] parity_arr [NUM_RS_UNITS];

   generate
      for (genvar gi = 0; gi < NUM_RS_UNITS; gi++) begin : g_unpack
         assign line_arr[gi]   = unit_lines[gi*DATA_W +: DATA_W];
         assign parity_arr[gi] = unit_paritys[gi*PARITY_W +: PARITY_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         num_blocks_reg <= '0;
         block_cnt_reg  <= '0;
         rd_cnt_reg     <= '0;
         line_cnt_reg   <= '0;
         unit_sel_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         num_blocks_reg <= num_blocks_next;
         block_cnt_reg  <= block_cnt_next;
         rd_cnt_reg     <= rd_cnt_next;
         line_cnt_reg   <= line_cnt_next;
         unit_sel_reg   <= unit_sel_next;
      end
   end

   always_comb begin
      state_next             = state_reg;
      num_blocks_next        = num_blocks_reg;
      block_cnt_next         = block_cnt_reg;
      rd_cnt_next            = rd_cnt_reg;
      line_cnt_next          = line_cnt_reg;
      unit_sel_next          = unit_sel_reg;
      req_rdy                = 1'b0;
      unit_line_rdys         = '0;
      dst_val                = 1'b0;
      dst_data               = '0;
      dst_last               = 1'b0;
      parity_mem_wr_val      = 1'b0;
      parity_mem_wr_addr     = block_cnt_reg[NUM_REQ_BLOCKS_W-1:0];
      parity_mem_wr_data     = parity_arr[unit_sel_reg];
      parity_mem_rd_req_val  = 1'b0;
      parity_mem_rd_req_addr = rd_cnt_reg[NUM_REQ_BLOCKS_W-1:0];
      parity_mem_rd_resp_rdy = 1'b0;

      case (state_reg)
         IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               num_blocks_next = req_num_blocks;
               block_cnt_next  = '0;
               line_cnt_next   = '0;
               unit_sel_next   = '0;
               rd_cnt_next     = '0;
               if (req_num_blocks != '0) state_next = DATA;
            end
         end
         DATA: begin
            dst_val                      = unit_line_vals[unit_sel_reg];
            dst_data                     = line_arr[unit_sel_reg];
            unit_line_rdys[unit_sel_reg] = dst_rdy;
            if (dst_val && dst_rdy) begin
               if (line_cnt_reg == LINE_W'(NUM_LINES - 1)) begin
                  // The unit presents its block parity alongside the last line.
                  parity_mem_wr_val = 1'b1;
                  line_cnt_next     = '0;
                  block_cnt_next    = block_cnt_reg + CNT_W'(1);
                  unit_sel_next     = (unit_sel_reg == NUM_RS_UNITS_W'(NUM_RS_UNITS - 1)) ?
                                      '0 : unit_sel_reg + NUM_RS_UNITS_W'(1);
                  if (block_cnt_reg == num_blocks_reg - CNT_W'(1)) state_next = PAR_REQ;
               end else begin
                  line_cnt_next = line_cnt_reg + LINE_W'(1);
               end
            end
         end
         PAR_REQ: begin
            parity_mem_rd_req_val = 1'b1;
            if (parity_mem_rd_req_rdy) state_next = PAR_RESP;
         end
         PAR_RESP: begin
            dst_val                = parity_mem_rd_resp_val;
            dst_data               = DATA_W'(parity_mem_rd_resp_data);
            parity_mem_rd_resp_rdy = dst_rdy;
            dst_last               = (rd_cnt_reg == num_blocks_reg - CNT_W'(1));
            if (dst_val && dst_rdy) begin
               if (dst_last) begin
                  state_next = IDLE;
               end else begin
                  rd_cnt_next = rd_cnt_reg + CNT_W'(1);
                  state_next  = PAR_REQ;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Keep every handshake quiet while reset is held, whatever the current state.
      if (rst) begin
         req_rdy                = 1'b0;
         unit_line_rdys         = '0;
         dst_val                = 1'b0;
         dst_data               = '0;
         dst_last               = 1'b0;
         parity_mem_wr_val      = 1'b0;
         parity_mem_rd_req_val  = 1'b0;
         parity_mem_rd_resp_rdy = 1'b0;
      end
   end

endmodule
